// File: rtl/csr_exu.sv
// csr_exu: multi-cycle Zicsr/SYSTEM execute unit (IDLE -> EXEC -> RESP).
// Optional CSR_ADDR_CHECK_EN flags unsupported CSR addresses as illegal.
module csr_exu (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_sys,
  input  logic [11:0] in_csr_addr,
  input  logic [4:0]  in_rs1_idx,
  input  logic [31:0] in_rs1_data,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_pc,
  output logic [11:0] csr_addr,
  input  logic [31:0] csr_rdata,
  output logic [31:0] csr_wdata,
  output logic        csr_wen,
  output logic        csr_ecall,
  output logic [31:0] pc,
  input  logic [31:0] csr_mtvec,
  input  logic [31:0] csr_mepc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_rd,
  output logic        out_rd_wen,
  output logic [31:0] out_wdata,
  output logic        out_redirect,
  output logic [31:0] out_redirect_pc,
  output logic        out_illegal
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state;
  logic [2:0]  f3_q;
  logic [1:0]  sys_q;
  logic [11:0] addr_q;
  logic [4:0]  idx_q;
  logic [4:0]  rd_q;
  logic [31:0] data_q;
  logic [31:0] pc_q;

  logic        exec;
  logic        is_csr;
  logic        is_ecall;
  logic        is_mret;
  logic        legal;
  logic        wen_ok;
  logic [31:0] src;
  logic [31:0] nval;

  assign exec     = (state == EXEC);
  assign is_csr   = (f3_q[1:0] != 2'b00);
  assign is_ecall = (f3_q == 3'b000) && (sys_q == 2'b01);
  assign is_mret  = (f3_q == 3'b000) && (sys_q == 2'b10);
  assign src      = f3_q[2] ? {27'b0, idx_q} : data_q;

  always_comb begin
    nval = src;
    unique case (1'b1)
      f3_q[1:0] == 2'b10: nval = csr_rdata | src;
      f3_q[1:0] == 2'b11: nval = csr_rdata & ~src;
      default:            nval = src;
    endcase
  end

`ifdef CSR_ADDR_CHECK_EN
  assign legal = (addr_q == 12'h300) || (addr_q == 12'h305) ||
                 (addr_q == 12'h341) || (addr_q == 12'h342);
`else
  assign legal = 1'b1;
`endif

  // set/clear forms with a zero source field read without writing
  assign wen_ok = is_csr && legal &&
                  ((f3_q[1:0] == 2'b01) || (idx_q != 5'd0));

  assign csr_addr  = exec ? addr_q : 12'd0;
  assign csr_wdata = (exec && is_csr) ? nval : 32'd0;
  assign csr_wen   = exec && wen_ok;
  assign csr_ecall = exec && is_ecall;
  assign pc        = exec ? pc_q : 32'd0;
  assign in_ready  = (state == IDLE) && rst;
  assign out_valid = (state == RESP);

`ifdef CSR_ADDR_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      out_illegal <= 1'b0;
    else if (exec)
      out_illegal <= is_csr && !legal;
  end
`else
  assign out_illegal = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      f3_q            <= 3'd0;
      sys_q           <= 2'd0;
      addr_q          <= 12'd0;
      idx_q           <= 5'd0;
      rd_q            <= 5'd0;
      data_q          <= 32'd0;
      pc_q            <= 32'd0;
      out_rd          <= 5'd0;
      out_rd_wen      <= 1'b0;
      out_wdata       <= 32'd0;
      out_redirect    <= 1'b0;
      out_redirect_pc <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            f3_q   <= in_funct3;
            sys_q  <= in_sys;
            addr_q <= in_csr_addr;
            idx_q  <= in_rs1_idx;
            rd_q   <= in_rd;
            data_q <= in_rs1_data;
            pc_q   <= in_pc;
            state  <= EXEC;
          end
        end
        EXEC: begin
          out_rd       <= rd_q;
          out_rd_wen   <= is_csr && (rd_q != 5'd0);
          out_wdata    <= (is_csr && legal) ? csr_rdata : 32'd0;
          out_redirect <= is_ecall || is_mret;
          out_redirect_pc <= is_ecall ? csr_mtvec :
                             is_mret  ? csr_mepc  : 32'd0;
          state        <= RESP;
        end
        RESP: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_exu.sv
// Directed bench for csr_exu with a small behavioural CSR file model.
// Expectations follow CSR_ADDR_CHECK_EN when it is defined.
module tb_csr_exu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_funct3 = 3'd0;
  logic [1:0]  in_sys = 2'd0;
  logic [11:0] in_csr_addr = 12'd0;
  logic [4:0]  in_rs1_idx = 5'd0;
  logic [31:0] in_rs1_data = 32'd0;
  logic [4:0]  in_rd = 5'd0;
  logic [31:0] in_pc = 32'd0;
  logic [11:0] csr_addr;
  logic [31:0] csr_rdata;
  logic [31:0] csr_wdata;
  logic        csr_wen;
  logic        csr_ecall;
  logic [31:0] pc;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  out_rd;
  logic        out_rd_wen;
  logic [31:0] out_wdata;
  logic        out_redirect;
  logic [31:0] out_redirect_pc;
  logic        out_illegal;

  int tests = 0;
  int fails = 0;

  logic [31:0] mstatus, mtvec, mepc, mcause;

  always #5 clk = ~clk;

  csr_exu dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_sys(in_sys),
    .in_csr_addr(in_csr_addr), .in_rs1_idx(in_rs1_idx),
    .in_rs1_data(in_rs1_data), .in_rd(in_rd), .in_pc(in_pc),
    .csr_addr(csr_addr), .csr_rdata(csr_rdata),
    .csr_wdata(csr_wdata), .csr_wen(csr_wen),
    .csr_ecall(csr_ecall), .pc(pc),
    .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_rd_wen(out_rd_wen),
    .out_wdata(out_wdata), .out_redirect(out_redirect),
    .out_redirect_pc(out_redirect_pc), .out_illegal(out_illegal)
  );

  // CSR file model: combinational read, write on strobe
  always_comb begin
    csr_rdata = 32'd0;
    case (csr_addr)
      12'h300: csr_rdata = mstatus;
      12'h305: csr_rdata = mtvec;
      12'h341: csr_rdata = mepc;
      12'h342: csr_rdata = mcause;
      default: csr_rdata = 32'd0;
    endcase
  end
  assign csr_mtvec = mtvec;
  assign csr_mepc  = mepc;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mstatus <= 32'h180;
      mtvec   <= 32'h8000_0000;
      mepc    <= 32'd0;
      mcause  <= 32'hB;
    end else begin
      if (csr_wen) begin
        case (csr_addr)
          12'h300: mstatus <= csr_wdata;
          12'h305: mtvec   <= csr_wdata;
          12'h341: mepc    <= csr_wdata;
          12'h342: mcause  <= csr_wdata;
          default: ;
        endcase
      end
      if (csr_ecall) begin
        mepc   <= pc;
        mcause <= 32'hB;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept edge, then return sampling inside EXEC (cycle 1).
  task automatic issue(input logic [2:0] f3, input logic [1:0] sys,
                       input logic [11:0] addr, input logic [4:0] idx,
                       input logic [31:0] data, input logic [4:0] rd,
                       input logic [31:0] ipc);
    in_funct3   = f3;
    in_sys      = sys;
    in_csr_addr = addr;
    in_rs1_idx  = idx;
    in_rs1_data = data;
    in_rd       = rd;
    in_pc       = ipc;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid    = 1'b0;
  endtask

  task automatic next;
    @(posedge clk); #1;
  endtask

  initial begin
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_csr_wen", {31'd0, csr_wen}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // CSRRW mtvec
    issue(3'b001, 2'd0, 12'h305, 5'd1, 32'h8000_0100, 5'd5, 32'd0);
    chk("rw_wen", {31'd0, csr_wen}, 32'd1);
    chk("rw_wdata", csr_wdata, 32'h8000_0100);
    chk("rw_addr", {20'd0, csr_addr}, 32'h305);
    chk("rw_in_ready_exec", {31'd0, in_ready}, 32'd0);
    next;
    chk("rw_out_valid", {31'd0, out_valid}, 32'd1);
    chk("rw_out_wdata", out_wdata, 32'h8000_0000);
    chk("rw_rd_wen", {31'd0, out_rd_wen}, 32'd1);
    chk("rw_rd", {27'd0, out_rd}, 32'd5);
    chk("rw_redirect", {31'd0, out_redirect}, 32'd0);
    chk("rw_wen_resp", {31'd0, csr_wen}, 32'd0);
    chk("rw_addr_resp", {20'd0, csr_addr}, 32'd0);
    next;
    chk("rw_idle", {31'd0, in_ready}, 32'd1);
    chk("mtvec_written", mtvec, 32'h8000_0100);

    // CSRRS with rs1=x0: read only
    issue(3'b010, 2'd0, 12'h300, 5'd0, 32'hFFFF_FFFF, 5'd6, 32'd0);
    chk("rs0_wen", {31'd0, csr_wen}, 32'd0);
    next;
    chk("rs0_out_wdata", out_wdata, 32'h180);
    next;

    // CSRRCI zimm=0: no write
    issue(3'b111, 2'd0, 12'h300, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'd0);
    chk("rci0_wen", {31'd0, csr_wen}, 32'd0);
    next;
    chk("rci0_rd_wen", {31'd0, out_rd_wen}, 32'd0);
    next;

    // CSRRSI zimm=8
    issue(3'b110, 2'd0, 12'h300, 5'd8, 32'd0, 5'd7, 32'd0);
    chk("rsi_wen", {31'd0, csr_wen}, 32'd1);
    chk("rsi_wdata", csr_wdata, 32'h188);
    next;
    chk("rsi_out_wdata", out_wdata, 32'h180);
    next;

    // Dependent read sees committed value
    issue(3'b010, 2'd0, 12'h300, 5'd0, 32'd0, 5'd8, 32'd0);
    next;
    chk("dep_out_wdata", out_wdata, 32'h188);
    next;

    // CSRRC mcause with register source
    issue(3'b011, 2'd0, 12'h342, 5'd2, 32'h1, 5'd9, 32'd0);
    chk("rc_wdata", csr_wdata, 32'hA);
    next;
    chk("rc_out_wdata", out_wdata, 32'hB);
    next;

    // ECALL
    issue(3'b000, 2'b01, 12'h000, 5'd0, 32'd0, 5'd0, 32'h8000_0040);
    chk("ecall_strobe", {31'd0, csr_ecall}, 32'd1);
    chk("ecall_pc", pc, 32'h8000_0040);
    chk("ecall_wen", {31'd0, csr_wen}, 32'd0);
    next;
    chk("ecall_redirect", {31'd0, out_redirect}, 32'd1);
    chk("ecall_target", out_redirect_pc, 32'h8000_0100);
    chk("ecall_rd_wen", {31'd0, out_rd_wen}, 32'd0);
    chk("ecall_strobe_off", {31'd0, csr_ecall}, 32'd0);
    chk("ecall_pc_off", pc, 32'd0);
    next;

    // MRET
    issue(3'b000, 2'b10, 12'h000, 5'd0, 32'd0, 5'd0, 32'd0);
    chk("mret_ecall", {31'd0, csr_ecall}, 32'd0);
    chk("mret_wen", {31'd0, csr_wen}, 32'd0);
    next;
    chk("mret_redirect", {31'd0, out_redirect}, 32'd1);
    chk("mret_target", out_redirect_pc, 32'h8000_0040);
    next;

    // SYSTEM NOP
    issue(3'b000, 2'b11, 12'h000, 5'd0, 32'd0, 5'd3, 32'h44);
    chk("nop_ecall", {31'd0, csr_ecall}, 32'd0);
    next;
    chk("nop_redirect", {31'd0, out_redirect}, 32'd0);
    chk("nop_rd_wen", {31'd0, out_rd_wen}, 32'd0);
    next;

    // Backpressure: response held, new requests ignored
    out_ready = 1'b0;
    issue(3'b001, 2'd0, 12'h341, 5'd4, 32'h1234_5678, 5'd10, 32'd0);
    next;
    in_funct3   = 3'b001;
    in_csr_addr = 12'h300;
    in_rs1_data = 32'hDEAD_BEEF;
    in_valid    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_wdata", out_wdata, 32'h8000_0040);
      chk("bp_rd", {27'd0, out_rd}, 32'd10);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_no_wen", {31'd0, csr_wen}, 32'd0);
      next;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("bp_last_valid", {31'd0, out_valid}, 32'd1);
    next;
    chk("bp_done_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_done_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_mstatus_kept", mstatus, 32'h188);
    chk("bp_mepc", mepc, 32'h1234_5678);

    // Unsupported address
    issue(3'b001, 2'd0, 12'h7C0, 5'd3, 32'h5, 5'd11, 32'd0);
`ifdef CSR_ADDR_CHECK_EN
    chk("ill_wen", {31'd0, csr_wen}, 32'd0);
    next;
    chk("ill_flag", {31'd0, out_illegal}, 32'd1);
`else
    chk("ill_wen", {31'd0, csr_wen}, 32'd1);
    next;
    chk("ill_flag", {31'd0, out_illegal}, 32'd0);
`endif
    chk("ill_wdata", out_wdata, 32'd0);
    chk("ill_rd_wen", {31'd0, out_rd_wen}, 32'd1);
    next;

    // Reset mid-EXEC
    issue(3'b001, 2'd0, 12'h300, 5'd1, 32'h0, 5'd1, 32'd0);
    chk("mid_wen_before", {31'd0, csr_wen}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_wen_rst", {31'd0, csr_wen}, 32'd0);
    chk("mid_valid_rst", {31'd0, out_valid}, 32'd0);
    chk("mid_wdata_rst", out_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    next;
    chk("mid_ready_rel", {31'd0, in_ready}, 32'd1);
    chk("mid_valid_rel", {31'd0, out_valid}, 32'd0);
    chk("mid_mstatus", mstatus, 32'h180);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/csr_exu.md
# csr_exu

Multi-cycle execute unit for Zicsr and SYSTEM instructions (CSRRW/RS/RC and immediate forms, ECALL, MRET) in the NPC core. It sits between decode and the CSR register file. It accepts one decoded instruction per handshake, performs the CSR read-modify-write through the CSR file's combinational read port and write strobe, and raises the ecall strobe. It then returns the rd writeback value and any PC redirect (trap to mtvec, return to mepc) to writeback through a valid/ready response.

## Interface
No parameters.
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low; clock and reset follow codebase naming, polarity and synchronicity fixed
- in_valid  in  1  decoded instruction present
- in_ready  out  1  unit can accept; high only in IDLE
- in_funct3  in  3  001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI, 000 SYSTEM
- in_sys  in  2  used when funct3=000: 01 ECALL, 10 MRET, other values are a NOP
- in_csr_addr  in  12  CSR address
- in_rs1_idx  in  5  rs1 index for register forms; zimm for immediate forms
- in_rs1_data  in  32  rs1 value
- in_rd  in  5  destination register
- in_pc  in  32  instruction PC
- csr_addr  out  12  address to CSR file
- csr_rdata  in  32  combinational read data from CSR file
- csr_wdata  out  32  write data
- csr_wen  out  1  write strobe, one cycle
- csr_ecall  out  1  ecall strobe, one cycle
- pc  out  32  PC for mepc capture
- csr_mtvec  in  32  current mtvec
- csr_mepc  in  32  current mepc
- out_valid  out  1  response present
- out_ready  in  1  writeback accepts
- out_rd  out  5  destination index
- out_rd_wen  out  1  rd write enable
- out_wdata  out  32  old CSR value, which is written to rd
- out_redirect  out  1  PC redirect request
- out_redirect_pc  out  32  redirect target
- out_illegal  out  1  unsupported CSR address (see Configuration)

## Operation
- FSM states: IDLE → EXEC → RESP → IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, all inputs are latched and the FSM moves to EXEC.
- EXEC lasts exactly one cycle.
  - csr_addr is set to the latched address. csr_rdata is sampled into out_wdata.
  - New value by operation:
    - RW/RWI: src
    - RS/RSI: old | src
    - RC/RCI: old & ~src
  - src is rs1_data for register forms. For immediate forms it is {27'b0, zimm}.
- csr_wen in EXEC:
  - RW/RWI: always asserted.
  - RS/RC and immediate variants: asserted only if the 5-bit source field is nonzero. With a zero source field, no write occurs and the read still happens.
- ECALL in EXEC: csr_ecall=1, pc=latched PC, csr_wen=0. Response carries out_redirect=1, out_redirect_pc=csr_mtvec sampled in EXEC, and out_rd_wen=0.
- MRET in EXEC: csr_wen=0. Response carries out_redirect=1, out_redirect_pc=csr_mepc sampled in EXEC, and out_rd_wen=0.
- SYSTEM NOP: no strobes, out_redirect=0, out_rd_wen=0.
- CSR ops: out_rd_wen=(rd!=0), out_redirect=0.
- RESP: out_valid=1 and response fields are held stable until out_valid&&out_ready, then the FSM returns to IDLE. There is no accept in RESP, so the unit holds a single outstanding instruction.
- csr_wen and csr_ecall are zero outside EXEC. csr_addr, csr_wdata and pc are 0 outside EXEC.

## Timing
- Accept edge at cycle 0. EXEC is cycle 1, and the CSR write and mepc/mcause capture happen on the edge ending cycle 1. out_valid goes high in cycle 2.
- Minimum issue-to-issue interval: 3 cycles, when out_ready is high in cycle 2.
- A back-to-back dependent CSR op sees the written value, because the write commits before the next EXEC.
- Reset (rst=0, asynchronous, at any state including EXEC or RESP):
  - FSM returns to IDLE.
  - Outputs are 0 except in_ready, which is 1 once rst is released.
  - A partially executed instruction is dropped with no strobe.
- in_valid while not in IDLE is ignored (in_ready=0).

## Configuration
- CSR_ADDR_CHECK_EN defined: an address other than 0x300, 0x305, 0x341 or 0x342 on a CSR op gives:
  - csr_wen suppressed
  - out_wdata=0
  - out_illegal=1
  - out_rd_wen=(rd!=0)
- CSR_ADDR_CHECK_EN undefined: out_illegal is tied 0 and the write strobe is forwarded unchanged. The CSR file ignores unknown addresses and returns 0.

## Test plan
- Reset: rst low mid-EXEC → csr_wen=0 immediately; after release in_ready=1 and out_valid=0.
- CSRRW 0x305 with rs1_data=0x8000_0100 and rd=5 → csr_wen pulse with wdata 0x8000_0100 in cycle 1; cycle 2 out_wdata=old mtvec, out_rd_wen=1.
- CSRRS 0x300 with rs1_idx=0 → no csr_wen; out_wdata=0x180. Then CSRRCI 0x300 with zimm=0x0 → no write. Then CSRRSI 0x300 with zimm=0x8 → wdata 0x188.
- ECALL at pc=0x8000_0040 with mtvec=0x8000_0100 → csr_ecall and pc=0x8000_0040 in cycle 1; response out_redirect=1, target 0x8000_0100. Then MRET → target 0x8000_0040.
- Backpressure: out_ready low for 4 cycles → response held stable and in_ready=0 throughout; completes on the first ready cycle.
- With CSR_ADDR_CHECK_EN: CSRRW 0x7C0 → out_illegal=1, no csr_wen, out_wdata=0. Without the macro: csr_wen=1 and out_illegal=0.
